// File: rtl/cpu_dbg_pkg.sv
// Shared run-control state encoding and default widths for the CPU debug block.
// Latency: n/a (types and constants only); backpressure: n/a.
package cpu_dbg_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_STEP = 2'd2
  } run_state_t;

  localparam int DEF_PC_W   = 8;
  localparam int DEF_NUM_BP = 2;
  localparam int DEF_STEP_W = 8;
  localparam int DEF_REG_AW = 4;

endpackage

// File: rtl/bp_match.sv
// Per-channel PC breakpoint comparators; the caller OR-reduces the vector.
// Latency: combinational; backpressure: none.
module bp_match
  import cpu_dbg_pkg::*;
#(
  parameter int PC_W   = DEF_PC_W,
  parameter int NUM_BP = DEF_NUM_BP
) (
  input  logic [PC_W-1:0]        pc,
  input  logic [NUM_BP-1:0]      bp_en,
  input  logic [NUM_BP*PC_W-1:0] bp_addr,
  output logic [NUM_BP-1:0]      match
);

  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_BP; i++) begin
      match[i] = bp_en[i] && (pc == bp_addr[i*PC_W +: PC_W]);
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/halt/step control producing the pipeline advance enable, with PC breakpoints and debug regfile arbitration.
// Latency: cpu_en is combinational, state/grant change on the next CLK edge; backpressure: none.
module cpu_run_ctrl
  import cpu_dbg_pkg::*;
#(
  parameter int PC_W   = DEF_PC_W,
  parameter int NUM_BP = DEF_NUM_BP,
  parameter int STEP_W = DEF_STEP_W,
  parameter int REG_AW = DEF_REG_AW
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   PAUSE,
  input  logic                   STEP,
  input  logic [STEP_W-1:0]      step_count,
  input  logic [PC_W-1:0]        pc,
  input  logic [NUM_BP-1:0]      bp_en,
  input  logic [NUM_BP*PC_W-1:0] bp_addr,
  input  logic                   dbg_req,
  input  logic [REG_AW-1:0]      dbg_ra,
  output logic                   cpu_en,
  output logic                   halted,
  output logic [NUM_BP-1:0]      bp_hit,
  output logic [STEP_W-1:0]      steps_left,
  output logic                   dbg_grant,
  output logic [REG_AW-1:0]      rf_dbg_ra
);

  run_state_t          state, state_nxt;
  logic                step_q;
  logic                step_pend, step_pend_nxt;
  logic                bp_skip;
  logic [NUM_BP-1:0]   bp_hit_nxt;
  logic [STEP_W-1:0]   steps_left_nxt;
  logic [NUM_BP-1:0]   match_raw, match_v;
  logic                bp_any;
  logic                step_edge;
  logic                grant_nxt;
  logic [STEP_W-1:0]   step_load;

  bp_match #(
    .PC_W   (PC_W),
    .NUM_BP (NUM_BP)
  ) u_bp_match (
    .pc      (pc),
    .bp_en   (bp_en),
    .bp_addr (bp_addr),
    .match   (match_raw)
  );

  // Suppress the breakpoint we just resumed from for the first cycle out of HALT.
  assign match_v   = bp_skip ? '0 : match_raw;
  assign bp_any    = |match_v;
  assign step_edge = STEP && !step_q;
  assign step_load = (step_count == '0) ? STEP_W'(1) : step_count;
  assign grant_nxt = dbg_req && (dbg_grant || (state == ST_HALT));
  assign halted    = (state == ST_HALT);

  always_comb begin
    state_nxt      = state;
    cpu_en         = 1'b0;
    step_pend_nxt  = step_pend;
    bp_hit_nxt     = bp_hit;
    steps_left_nxt = steps_left;
    case (state)
      ST_RUN: begin
        cpu_en = !bp_any && !PAUSE;
        if (PAUSE || bp_any) begin
          state_nxt  = ST_HALT;
          bp_hit_nxt = match_v;
        end
      end
      ST_HALT: begin
        // While debug owns the regfile the pipeline must stay frozen; remember the step for later.
        if (dbg_grant) begin
          if (step_edge) step_pend_nxt = 1'b1;
        end else if (step_edge || step_pend) begin
          state_nxt      = ST_STEP;
          steps_left_nxt = step_load;
          step_pend_nxt  = 1'b0;
        end else if (!PAUSE) begin
          state_nxt = ST_RUN;
        end
        if (state_nxt != ST_HALT) bp_hit_nxt = '0;
      end
      ST_STEP: begin
        cpu_en = 1'b1;
        if (steps_left <= STEP_W'(1)) begin
          state_nxt      = ST_HALT;
          steps_left_nxt = '0;
        end else begin
          steps_left_nxt = steps_left - STEP_W'(1);
        end
      end
      default: state_nxt = ST_HALT;
    endcase
    if (RST) cpu_en = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= ST_HALT;
      step_q     <= 1'b1;
      step_pend  <= 1'b0;
      bp_skip    <= 1'b0;
      bp_hit     <= '0;
      steps_left <= '0;
      dbg_grant  <= 1'b0;
      rf_dbg_ra  <= '0;
    end else begin
      state      <= state_nxt;
      step_q     <= STEP;
      step_pend  <= step_pend_nxt;
      bp_skip    <= (state == ST_HALT) && (state_nxt != ST_HALT);
      bp_hit     <= bp_hit_nxt;
      steps_left <= steps_left_nxt;
      dbg_grant  <= grant_nxt;
      if (grant_nxt) rf_dbg_ra <= dbg_ra;
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Scoreboard bench for cpu_run_ctrl: directed test-plan scenarios followed by randomized traffic.
module tb_cpu_run_ctrl;

  logic        clk = 1'b0;
  logic        rst, pause, step, dbg_req;
  logic [7:0]  step_count, pc;
  logic [1:0]  bp_en;
  logic [15:0] bp_addr;
  logic [3:0]  dbg_ra;
  logic        cpu_en, halted, dbg_grant;
  logic [1:0]  bp_hit;
  logic [7:0]  steps_left;
  logic [3:0]  rf_dbg_ra;

  always #5 clk = ~clk;

  cpu_run_ctrl #(.PC_W(8), .NUM_BP(2), .STEP_W(8), .REG_AW(4)) dut (
    .CLK(clk), .RST(rst), .PAUSE(pause), .STEP(step), .step_count(step_count),
    .pc(pc), .bp_en(bp_en), .bp_addr(bp_addr), .dbg_req(dbg_req), .dbg_ra(dbg_ra),
    .cpu_en(cpu_en), .halted(halted), .bp_hit(bp_hit), .steps_left(steps_left),
    .dbg_grant(dbg_grant), .rf_dbg_ra(rf_dbg_ra)
  );

  typedef struct {
    bit       chk;
    bit       en;
    bit       halted;
    bit [1:0] hit;
    bit [7:0] left;
    bit       grant;
    bit [3:0] ra;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int adv_cnt = 0;

  // Reference model: "halted" flag plus a count of step cycles still owed.
  bit       m_known = 0;
  bit       m_halt  = 1;
  int       m_left  = 0;
  bit       m_grant = 0;
  bit [3:0] m_ra    = 0;
  bit [1:0] m_hit   = 0;
  bit       m_pend  = 0;
  bit       m_skip  = 0;
  bit       m_prev  = 1;
  bit [7:0] pc_r    = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic cycle(input bit r, input bit p, input bit s, input bit [7:0] sc,
                       input bit [1:0] be, input bit [15:0] ba, input bit rq, input bit [3:0] ra);
    exp_t     e;
    bit [1:0] mv;
    bit       running, stepping, stp_edge, en, old_halt, new_grant;
    rst = r; pause = p; step = s; step_count = sc; bp_en = be; bp_addr = ba;
    dbg_req = rq; dbg_ra = ra; pc = pc_r;
    for (int i = 0; i < 2; i++) mv[i] = be[i] && (pc_r == ba[i*8 +: 8]) && !m_skip;
    running  = !m_halt && (m_left == 0);
    stepping = !m_halt && (m_left > 0);
    if (r)             en = 1'b0;
    else if (stepping) en = 1'b1;
    else if (running)  en = (mv == 2'b00) && !p;
    else               en = 1'b0;
    e.chk = m_known; e.en = en; e.halted = m_halt; e.hit = m_hit;
    e.left = 8'(m_left); e.grant = m_grant; e.ra = m_ra;
    sb.push_back(e);
    if (r) begin
      m_known = 1; m_halt = 1; m_left = 0; m_grant = 0; m_ra = 0;
      m_hit = 0; m_pend = 0; m_skip = 0; m_prev = 1;
    end else begin
      old_halt = m_halt;
      stp_edge = s && !m_prev;
      m_skip   = 0;
      if (running) begin
        if (p || mv != 2'b00) begin m_halt = 1; m_hit = mv; end
      end else if (stepping) begin
        m_left = m_left - 1;
        if (m_left == 0) m_halt = 1;
      end else begin
        if (m_grant) begin
          if (stp_edge) m_pend = 1;
        end else if (stp_edge || m_pend) begin
          m_halt = 0; m_left = (sc == 0) ? 1 : int'(sc); m_pend = 0; m_skip = 1; m_hit = 0;
        end else if (!p) begin
          m_halt = 0; m_skip = 1; m_hit = 0;
        end
      end
      new_grant = rq && (m_grant || old_halt);
      if (new_grant) m_ra = ra;
      m_grant = new_grant;
      m_prev  = s;
    end
    @(posedge clk);
    #1;
    if (en) pc_r = pc_r + 8'd1;
  endtask

  // Monitor: one expected record per cycle, compared mid-cycle.
  exp_t me;
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      me = sb.pop_front();
      if (cpu_en === 1'b1) adv_cnt++;
      if (me.chk) begin
        chk("cpu_en", int'(cpu_en), int'(me.en));
        chk("halted", int'(halted), int'(me.halted));
        chk("bp_hit", int'(bp_hit), int'(me.hit));
        chk("steps_left", int'(steps_left), int'(me.left));
        chk("dbg_grant", int'(dbg_grant), int'(me.grant));
        chk("rf_dbg_ra", int'(rf_dbg_ra), int'(me.ra));
      end
    end
  end

  initial begin
    int       a0, n;
    bit       rp, rs, rrq;
    bit [1:0] rbe;
    bit [15:0] rba;
    bit [15:0] ba12;
    rst = 1; pause = 1; step = 1; step_count = 0; pc = 0;
    bp_en = 0; bp_addr = 0; dbg_req = 0; dbg_ra = 0;
    @(posedge clk); #1;

    // STEP held high through reset must not produce a step.
    cycle(1, 1, 1, 3, 0, 0, 0, 0);
    cycle(1, 1, 1, 3, 0, 0, 0, 0);
    chk("reset_halted", int'(halted), 1);
    chk("reset_steps_left", int'(steps_left), 0);
    chk("reset_bp_hit", int'(bp_hit), 0);
    a0 = adv_cnt;
    repeat (3) cycle(0, 1, 1, 3, 0, 0, 0, 0);
    cycle(0, 1, 0, 3, 0, 0, 0, 0);
    chk("step_held_rst_adv", adv_cnt - a0, 0);

    // Unpause: one halted cycle then continuous advance.
    a0 = adv_cnt;
    repeat (5) cycle(0, 0, 0, 3, 0, 0, 0, 0);
    chk("run_adv", adv_cnt - a0, 4);
    cycle(0, 1, 0, 3, 0, 0, 0, 0);
    chk("pause_halted", int'(halted), 1);

    // Three-cycle step.
    a0 = adv_cnt;
    cycle(0, 1, 1, 3, 0, 0, 0, 0);
    repeat (6) cycle(0, 1, 0, 3, 0, 0, 0, 0);
    chk("step3_adv", adv_cnt - a0, 3);
    chk("step3_halted", int'(halted), 1);
    chk("step3_left", int'(steps_left), 0);

    // step_count of zero behaves as one.
    a0 = adv_cnt;
    cycle(0, 1, 1, 0, 0, 0, 0, 0);
    repeat (4) cycle(0, 1, 0, 0, 0, 0, 0, 0);
    chk("step0_adv", adv_cnt - a0, 1);

    // Breakpoint on channel 1 at 8'h12, then resume past it.
    ba12 = {8'h12, 8'h40};
    pc_r = 8'h0E;
    n = 0;
    while (pc_r != 8'h12 && n < 40) begin
      cycle(0, 0, 0, 0, 2'b10, ba12, 0, 0);
      n++;
    end
    chk("bp_reach_pc", int'(pc_r), 8'h12);
    cycle(0, 0, 0, 0, 2'b10, ba12, 0, 0);
    chk("bp_halted", int'(halted), 1);
    chk("bp_hit_vec", int'(bp_hit), 2);
    chk("bp_pc_held", int'(pc_r), 8'h12);
    repeat (4) cycle(0, 0, 0, 0, 2'b10, ba12, 0, 0);
    chk("bp_resume_pc", int'(pc_r), 8'h15);
    chk("bp_resume_running", int'(halted), 0);

    // Debug grant, step deferred while granted.
    repeat (2) cycle(0, 1, 0, 4, 0, 0, 0, 0);
    cycle(0, 1, 0, 4, 0, 0, 1, 5);
    chk("grant_latency", int'(dbg_grant), 1);
    cycle(0, 1, 0, 4, 0, 0, 1, 5);
    chk("grant_ra", int'(rf_dbg_ra), 5);
    a0 = adv_cnt;
    cycle(0, 1, 1, 4, 0, 0, 1, 5);
    repeat (3) cycle(0, 1, 0, 4, 0, 0, 1, 5);
    chk("grant_step_adv", adv_cnt - a0, 0);
    a0 = adv_cnt;
    repeat (8) cycle(0, 1, 0, 4, 0, 0, 0, 5);
    chk("pend_step_adv", adv_cnt - a0, 4);
    chk("pend_step_grant", int'(dbg_grant), 0);

    // Reset in the second cycle of a five-cycle step.
    cycle(0, 1, 1, 5, 0, 0, 0, 0);
    cycle(0, 1, 0, 5, 0, 0, 0, 0);
    cycle(1, 1, 0, 5, 0, 0, 0, 0);
    chk("rst_mid_halted", int'(halted), 1);
    chk("rst_mid_left", int'(steps_left), 0);
    chk("rst_mid_cpu_en", int'(cpu_en), 0);
    chk("rst_mid_grant", int'(dbg_grant), 0);
    chk("rst_mid_ra", int'(rf_dbg_ra), 0);
    chk("rst_mid_hit", int'(bp_hit), 0);
    cycle(0, 1, 0, 5, 0, 0, 0, 0);

    // Randomized traffic against the model.
    rp = 0; rs = 0; rrq = 0; rbe = 2'b01; rba = {8'h09, 8'h04}; pc_r = 0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(15) == 0) rp = ~rp;
      if ($urandom_range(5) == 0) rs = ~rs;
      if ($urandom_range(9) == 0) rrq = ~rrq;
      if ($urandom_range(49) == 0) begin
        rbe = 2'($urandom);
        rba[7:0]  = 8'($urandom_range(0, 31));
        rba[15:8] = 8'($urandom_range(0, 31));
      end
      if ($urandom_range(19) == 0 || pc_r > 8'd40) pc_r = 8'($urandom_range(0, 31));
      cycle(($urandom_range(199) == 0), rp, rs, 8'($urandom_range(0, 6)), rbe, rba,
            rrq, 4'($urandom));
    end

    @(negedge clk); #1;
    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
